// File: rtl/spi_codec_if.sv
// spi_codec_if: mode-0 SPI master running one full-duplex frame per sample tick
module spi_codec_if #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sample_tick_i,
  input  logic [DATA_W-1:0] dac_data_i,
  input  logic              clr_overrun_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              sclk_o,
  output logic              cs_n_o,
  output logic [DATA_W-1:0] adc_data_o,
  output logic              adc_valid_o,
  output logic              busy_o,
  output logic              overrun_o
);
  localparam int CMAX = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              hi_q, hi_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, adc_q, adc_d;
  logic [1:0]        miso_q;
  logic              miso_s;
  logic              mosi_q, mosi_d, sclk_q, sclk_d, cs_n_q, cs_n_d, busy_q, busy_d;
  logic              valid_q, valid_d, ovr_q, ovr_d;
  assign miso_s      = miso_q[1];
  assign mosi_o      = mosi_q;
  assign sclk_o      = sclk_q;
  assign cs_n_o      = cs_n_q;
  assign adc_data_o  = adc_q;
  assign adc_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign overrun_o   = ovr_q;
  // Frame sequencing; pin levels are derived from the next state so every output is a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    adc_d   = adc_q;
    valid_d = 1'b0;
    ovr_d   = (sample_tick_i && state_q != IDLE) || (ovr_q && !clr_overrun_i);
    case (state_q)
      IDLE:
        if (sample_tick_i) begin
          state_d = SETUP;
          tx_d    = dac_data_i;
          cnt_d   = '0;
        end
      SETUP:
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      SHIFT:
        if (cnt_q != CW'(CLK_DIV - 1)) cnt_d = cnt_q + 1'b1;
        else begin
          cnt_d = '0;
          hi_d  = !hi_q;
          if (hi_q) begin
            rx_d = {rx_q[DATA_W-2:0], miso_s};
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
            if (bit_q == BW'(DATA_W - 1)) state_d = HOLD;
            else bit_d = bit_q + 1'b1;
          end
        end
      HOLD:
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = IDLE;
          adc_d   = rx_q;
          valid_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    cs_n_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    sclk_d = state_d == SHIFT && hi_d;
    mosi_d = (state_d == SETUP || state_d == SHIFT) ? tx_d[DATA_W-1] : 1'b0;
  end
  // State, shift registers, miso synchronizer and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      adc_q   <= '0;
      miso_q  <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      adc_q   <= adc_d;
      miso_q  <= {miso_q[0], miso_i};
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_spi_codec_if.sv
// tb_spi_codec_if: directed checks of the SPI codec master (loopback, codec model, overrun, reset, variant)
module tb_spi_codec_if;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, tick1, tick2, clr, loop_en;
  logic [15:0] dac1, dac2, codec_word, adc1, adc2;
  logic        miso1, mosi1, sclk1, cs1, v1, busy1, ovr1;
  logic        mosi2, sclk2, cs2, v2, busy2, ovr2;
  logic        codec_bit;
  int          n_cmp = 0, n_bad = 0;
  assign miso1 = loop_en ? mosi1 : codec_bit;
  spi_codec_if dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick1), .dac_data_i(dac1),
    .clr_overrun_i(clr), .miso_i(miso1), .mosi_o(mosi1), .sclk_o(sclk1),
    .cs_n_o(cs1), .adc_data_o(adc1), .adc_valid_o(v1), .busy_o(busy1), .overrun_o(ovr1)
  );
  spi_codec_if #(.DATA_W(16), .CLK_DIV(3), .CS_SETUP(1)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick2), .dac_data_i(dac2),
    .clr_overrun_i(clr), .miso_i(mosi2), .mosi_o(mosi2), .sclk_o(sclk2),
    .cs_n_o(cs2), .adc_data_o(adc2), .adc_valid_o(v2), .busy_o(busy2), .overrun_o(ovr2)
  );
  logic        sclk_p = 1'b0, cs_p = 1'b1;
  int          rises = 0, highs = 0, valids = 0;
  logic [15:0] cap = '0, codec_sr = '0;
  assign codec_bit = codec_sr[15];
  // Bus monitor on dut1 plus a mode-0 codec that shifts its word out on sclk falling edges
  always @(negedge clk) begin
    if (sclk1 && !sclk_p) begin
      rises <= rises + 1;
      cap   <= {cap[14:0], mosi1};
    end
    if (sclk1) highs <= highs + 1;
    if (v1) valids <= valids + 1;
    if (!cs1 && cs_p) codec_sr <= codec_word;
    else if (!sclk1 && sclk_p) codec_sr <= {codec_sr[14:0], 1'b0};
    sclk_p <= sclk1;
    cs_p   <= cs1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input bit which, input logic [15:0] d);
    if (which) begin dac2 = d; tick2 = 1'b1; end
    else begin dac1 = d; tick1 = 1'b1; end
    @(negedge clk);
    tick1 = 1'b0;
    tick2 = 1'b0;
    dac1  = 16'hFFFF;
    dac2  = 16'hFFFF;
    chk(which ? "cs2_fall" : "cs_fall", {31'b0, which ? cs2 : cs1}, 32'd0);
  endtask
  task automatic finish(input bit which, input int start, input int exp_lat, input logic [15:0] exp_d);
    int lat = start;
    while (!(which ? v2 : v1) && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("adc_data", {16'b0, which ? adc2 : adc1}, {16'b0, exp_d});
    chk("cs_rise", {31'b0, which ? cs2 : cs1}, 32'd1);
  endtask
  int r0, h0, v0;
  initial begin
    rst_n = 1'b0; tick1 = 1'b0; tick2 = 1'b0; clr = 1'b0; loop_en = 1'b1;
    dac1 = '0; dac2 = '0; codec_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'b0, cs1}, 1);
    chk("rst_sclk", {31'b0, sclk1}, 0);
    chk("rst_mosi", {31'b0, mosi1}, 0);
    chk("rst_adc", {16'b0, adc1}, 0);
    chk("rst_valid", {31'b0, v1}, 0);
    chk("rst_busy", {31'b0, busy1}, 0);
    chk("rst_ovr", {31'b0, ovr1}, 0);
    chk("rst_cs2", {31'b0, cs2}, 1);
    rst_n = 1'b1;
    @(negedge clk);
    r0 = rises; h0 = highs;
    launch(0, 16'hA5C3);
    chk("busy_t1", {31'b0, busy1}, 1);
    finish(0, 1, 133, 16'hA5C3);
    chk("sclk_rises", rises - r0, 16);
    chk("sclk_high_cyc", highs - h0, 64);
    chk("mosi_loop", {16'b0, cap}, 32'h0000A5C3);
    @(negedge clk);
    chk("valid_pulse", {31'b0, v1}, 0);
    chk("busy_idle", {31'b0, busy1}, 0);
    loop_en = 1'b0;
    codec_word = 16'h8001;
    launch(0, 16'h7FFE);
    finish(0, 1, 133, 16'h8001);
    chk("mosi_stream", {16'b0, cap}, 32'h00007FFE);
    loop_en = 1'b1;
    r0 = rises;
    launch(0, 16'h1234);
    repeat (49) @(negedge clk);
    chk("ovr_pre", {31'b0, ovr1}, 0);
    tick1 = 1'b1;
    dac1  = 16'h0F0F;
    @(negedge clk);
    tick1 = 1'b0;
    chk("ovr_set", {31'b0, ovr1}, 1);
    finish(0, 51, 133, 16'h1234);
    chk("ovr_rises", rises - r0, 16);
    repeat (5) @(negedge clk);
    chk("ovr_no_frame", {31'b0, busy1}, 0);
    chk("ovr_sticky", {31'b0, ovr1}, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr", {31'b0, ovr1}, 0);
    launch(0, 16'h1357);
    finish(0, 1, 133, 16'h1357);
    launch(0, 16'h2468);
    finish(0, 1, 133, 16'h2468);
    @(negedge clk);
    v0 = valids;
    launch(0, 16'h5A5A);
    repeat (59) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_cs_n", {31'b0, cs1}, 1);
    chk("mid_rst_sclk", {31'b0, sclk1}, 0);
    chk("mid_rst_busy", {31'b0, busy1}, 0);
    chk("mid_rst_adc", {16'b0, adc1}, 0);
    repeat (150) @(negedge clk);
    chk("mid_rst_no_valid", valids - v0, 0);
    launch(0, 16'h3C96);
    finish(0, 1, 133, 16'h3C96);
    launch(1, 16'h9A5B);
    finish(1, 1, 99, 16'h9A5B);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
